// File: rtl/gc_input_pkg.sv
// gc_input_pkg: shared widths, button/axis indices, neutral values and conversion helpers
// Ports: none (package). Imported by gc_pad_channel and gc_input_frame_sync.
package gc_input_pkg;
    localparam int GC_BTN_W    = 12;
    localparam int GC_AXIS_W   = 8;
    localparam int GC_NUM_AXES = 6;
    localparam int GC_AXES_W   = GC_AXIS_W * GC_NUM_AXES;
    localparam int GC_STICKS   = 4;
    localparam int GC_TRIGS    = 2;
    typedef enum int {
        BTN_A = 0, BTN_B, BTN_X, BTN_Y, BTN_START, BTN_L, BTN_R, BTN_Z,
        BTN_D_UP, BTN_D_DOWN, BTN_D_RIGHT, BTN_D_LEFT
    } gc_btn_e;
    typedef enum int {
        AX_JOY_X = 0, AX_JOY_Y, AX_C_X, AX_C_Y, AX_L_TRIG, AX_R_TRIG
    } gc_axis_e;
    localparam logic [GC_BTN_W-1:0]  GC_BTN_NEUTRAL   = '0;
    localparam logic [GC_AXIS_W-1:0] GC_STICK_NEUTRAL = 8'h80;
    localparam logic [GC_AXES_W-1:0] GC_AXES_NEUTRAL  = 48'h0000_8080_8080;
    // Offset-binary stick to two's complement, zeroed inside the deadzone.
    // Magnitude of -128 wraps to 8'h80 = 128 unsigned, which is still correct.
    function automatic logic [7:0] stick_dz(input logic [7:0] raw, input logic [7:0] dz);
        logic [7:0] s;
        logic [7:0] mag;
        s   = {~raw[7], raw[6:0]};
        mag = s[7] ? (~s + 8'd1) : s;
        return (mag < dz) ? 8'd0 : s;
    endfunction
    function automatic logic [7:0] trig_dz(input logic [7:0] raw, input logic [7:0] dz);
        return (raw < dz) ? 8'd0 : raw;
    endfunction
endpackage

// File: rtl/gc_pad_channel.sv
// gc_pad_channel: one pad's staging, frame commit, event/deadzone logic and poll timeout
// Ports: i_clk, i_rst (async high), i_commit (frame edge), i_valid/i_buttons/i_axes (poll),
//        o_held/o_pressed/o_released (buttons), o_stick (4x s8), o_trigger (2x u8), o_connected
module gc_pad_channel
    import gc_input_pkg::*;
#(
    parameter int DEADZONE       = 12,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_commit,
    input  logic                           i_valid,
    input  logic [GC_BTN_W-1:0]            i_buttons,
    input  logic [GC_AXES_W-1:0]           i_axes,
    output logic [GC_BTN_W-1:0]            o_held,
    output logic [GC_BTN_W-1:0]            o_pressed,
    output logic [GC_BTN_W-1:0]            o_released,
    output logic [GC_STICKS*GC_AXIS_W-1:0] o_stick,
    output logic [GC_TRIGS*GC_AXIS_W-1:0]  o_trigger,
    output logic                           o_connected
);
    localparam logic [7:0] DZ = 8'(DEADZONE);
    localparam logic [7:0] TO = 8'(TIMEOUT_FRAMES);
    logic [GC_BTN_W-1:0]            r_stage_btn;
    logic [GC_AXES_W-1:0]           r_stage_axes;
    logic                           r_seen;
    logic [7:0]                     r_cnt;
    logic [GC_BTN_W-1:0]            r_held, r_pressed, r_released;
    logic [GC_STICKS*GC_AXIS_W-1:0] r_stick;
    logic [GC_TRIGS*GC_AXIS_W-1:0]  r_trigger;
    logic                           r_connected;
    logic [7:0]                     w_cnt_next;
    logic [GC_STICKS*GC_AXIS_W-1:0] w_stick;
    logic [GC_TRIGS*GC_AXIS_W-1:0]  w_trigger;
    assign w_cnt_next = r_seen ? 8'd0 : ((r_cnt >= TO) ? TO : r_cnt + 8'd1);
    always_comb begin
        w_stick   = '0;
        w_trigger = '0;
        for (int k = 0; k < GC_STICKS; k++)
            w_stick[k*GC_AXIS_W +: GC_AXIS_W] = stick_dz(r_stage_axes[k*GC_AXIS_W +: GC_AXIS_W], DZ);
        for (int k = 0; k < GC_TRIGS; k++)
            w_trigger[k*GC_AXIS_W +: GC_AXIS_W] =
                trig_dz(r_stage_axes[(k+GC_STICKS)*GC_AXIS_W +: GC_AXIS_W], DZ);
    end
    // A poll landing in the commit cycle overrides the timeout neutralisation and
    // re-sets seen after the clear, so it counts toward the following frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage_btn  <= GC_BTN_NEUTRAL;
            r_stage_axes <= GC_AXES_NEUTRAL;
            r_seen       <= 1'b0;
            r_cnt        <= TO;
            r_held       <= '0;
            r_pressed    <= '0;
            r_released   <= '0;
            r_stick      <= '0;
            r_trigger    <= '0;
            r_connected  <= 1'b0;
        end else begin
            if (i_commit) begin
                r_pressed   <= r_stage_btn & ~r_held;
                r_released  <= ~r_stage_btn & r_held;
                r_held      <= r_stage_btn;
                r_stick     <= w_stick;
                r_trigger   <= w_trigger;
                r_cnt       <= w_cnt_next;
                r_connected <= w_cnt_next < TO;
                r_seen      <= 1'b0;
                if (w_cnt_next == TO) begin
                    r_stage_btn  <= GC_BTN_NEUTRAL;
                    r_stage_axes <= GC_AXES_NEUTRAL;
                end
            end
            if (i_valid) begin
                r_stage_btn  <= i_buttons;
                r_stage_axes <= i_axes;
                r_seen       <= 1'b1;
            end
        end
    end
    assign o_held      = r_held;
    assign o_pressed   = r_pressed;
    assign o_released  = r_released;
    assign o_stick     = r_stick;
    assign o_trigger   = r_trigger;
    assign o_connected = r_connected;
endmodule

// File: rtl/gc_input_frame_sync.sv
// gc_input_frame_sync: commits N pads' latest polls once per frame at vsync onset
// Ports: clk_100MHz, reset (async high), vsync, pad_valid/pad_buttons/pad_axes (per pad),
//        frame_strobe, btn_held/btn_pressed/btn_released, stick_out, trigger_out, pad_connected
module gc_input_frame_sync
    import gc_input_pkg::*;
#(
    parameter int NUM_PADS         = 1,
    parameter int DEADZONE         = 12,
    parameter int TIMEOUT_FRAMES   = 8,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                                 clk_100MHz,
    input  logic                                 reset,
    input  logic                                 vsync,
    input  logic [NUM_PADS-1:0]                  pad_valid,
    input  logic [NUM_PADS*GC_BTN_W-1:0]         pad_buttons,
    input  logic [NUM_PADS*GC_AXES_W-1:0]        pad_axes,
    output logic                                 frame_strobe,
    output logic [NUM_PADS*GC_BTN_W-1:0]         btn_held,
    output logic [NUM_PADS*GC_BTN_W-1:0]         btn_pressed,
    output logic [NUM_PADS*GC_BTN_W-1:0]         btn_released,
    output logic [NUM_PADS*GC_STICKS*GC_AXIS_W-1:0] stick_out,
    output logic [NUM_PADS*GC_TRIGS*GC_AXIS_W-1:0]  trigger_out,
    output logic [NUM_PADS-1:0]                  pad_connected
);
    localparam logic ACTIVE_LVL = (VSYNC_ACTIVE_LOW == 0);
    logic r_vsync;
    logic r_strobe;
    logic w_edge;
    // Edge = previous sample inactive, current sample active.
    assign w_edge = (r_vsync != ACTIVE_LVL) && (vsync == ACTIVE_LVL);
    // Resetting to the active level keeps a vsync already active at release from
    // producing a spurious commit.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_vsync  <= ACTIVE_LVL;
            r_strobe <= 1'b0;
        end else begin
            r_vsync  <= vsync;
            r_strobe <= w_edge;
        end
    end
    assign frame_strobe = r_strobe;
    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        gc_pad_channel #(
            .DEADZONE      (DEADZONE),
            .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
        ) u_ch (
            .i_clk      (clk_100MHz),
            .i_rst      (reset),
            .i_commit   (w_edge),
            .i_valid    (pad_valid[g]),
            .i_buttons  (pad_buttons[g*GC_BTN_W +: GC_BTN_W]),
            .i_axes     (pad_axes[g*GC_AXES_W +: GC_AXES_W]),
            .o_held     (btn_held[g*GC_BTN_W +: GC_BTN_W]),
            .o_pressed  (btn_pressed[g*GC_BTN_W +: GC_BTN_W]),
            .o_released (btn_released[g*GC_BTN_W +: GC_BTN_W]),
            .o_stick    (stick_out[g*GC_STICKS*GC_AXIS_W +: GC_STICKS*GC_AXIS_W]),
            .o_trigger  (trigger_out[g*GC_TRIGS*GC_AXIS_W +: GC_TRIGS*GC_AXIS_W]),
            .o_connected(pad_connected[g])
        );
    end
endmodule

// File: tb/tb_gc_input_frame_sync.sv
// tb_gc_input_frame_sync: directed scenarios for the two-pad frame-synchronised input block
module tb_gc_input_frame_sync;
    localparam logic [47:0] NEUT = 48'h0000_8080_8080;
    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic [1:0]  pad_valid;
    logic [11:0] btn [2];
    logic [47:0] ax  [2];
    logic        frame_strobe;
    logic [23:0] btn_held, btn_pressed, btn_released;
    logic [63:0] stick_out;
    logic [31:0] trigger_out;
    logic [1:0]  pad_connected;
    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;

    gc_input_frame_sync #(
        .NUM_PADS(2), .DEADZONE(12), .TIMEOUT_FRAMES(8), .VSYNC_ACTIVE_LOW(1)
    ) dut (
        .clk_100MHz   (clk),
        .reset        (reset),
        .vsync        (vsync),
        .pad_valid    (pad_valid),
        .pad_buttons  ({btn[1], btn[0]}),
        .pad_axes     ({ax[1], ax[0]}),
        .frame_strobe (frame_strobe),
        .btn_held     (btn_held),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .stick_out    (stick_out),
        .trigger_out  (trigger_out),
        .pad_connected(pad_connected)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_strobe === 1'b1) n_strobe++;

    task automatic poll(input int p, input logic [11:0] b, input logic [47:0] a);
        @(posedge clk); #1;
        btn[p] = b;
        ax[p] = a;
        pad_valid[p] = 1'b1;
        @(posedge clk); #1;
        pad_valid[p] = 1'b0;
    endtask

    // Falling vsync; commit lands on the first posedge after the drop.
    task automatic frame();
        @(posedge clk); #1 vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int s0;
        n_vec++;
        if ({frame_strobe, btn_held, btn_pressed, btn_released, stick_out, trigger_out, pad_connected} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got held=%h stick=%h trig=%h conn=%b strobe=%b want all 0",
                     btn_held, stick_out, trigger_out, pad_connected, frame_strobe);
        end
        for (int k = 1; k <= 9; k++) begin
            s0 = n_strobe;
            frame();
            n_vec++;
            if (n_strobe - s0 !== 1) begin
                n_err++;
                $display("FAIL idle_strobe frame %0d: got %0d strobes want 1", k, n_strobe - s0);
            end
            n_vec++;
            if (pad_connected !== 2'b00) begin
                n_err++;
                $display("FAIL idle_connected frame %0d: got %b want 00", k, pad_connected);
            end
        end
        n_vec++;
        if ({btn_held, btn_pressed, btn_released, stick_out, trigger_out} !== '0) begin
            n_err++;
            $display("FAIL idle_outputs: got held=%h stick=%h trig=%h want 0", btn_held, stick_out, trigger_out);
        end
    endtask

    task automatic test_press_release();
        logic [11:0] pb [4] = '{12'h001, 12'h001, 12'h000, 12'h000};
        logic [11:0] eh [4] = '{12'h001, 12'h001, 12'h000, 12'h000};
        logic [11:0] ep [4] = '{12'h001, 12'h000, 12'h000, 12'h000};
        logic [11:0] er [4] = '{12'h000, 12'h000, 12'h001, 12'h000};
        for (int k = 0; k < 4; k++) begin
            poll(0, pb[k], NEUT);
            frame();
            n_vec++;
            if ({btn_held[11:0], btn_pressed[11:0], btn_released[11:0]} !== {eh[k], ep[k], er[k]}) begin
                n_err++;
                $display("FAIL press_release step %0d: got h/p/r=%h/%h/%h want %h/%h/%h", k,
                         btn_held[11:0], btn_pressed[11:0], btn_released[11:0], eh[k], ep[k], er[k]);
            end
            n_vec++;
            if (pad_connected[0] !== 1'b1) begin
                n_err++;
                $display("FAIL press_connected step %0d: got %b want 1", k, pad_connected[0]);
            end
        end
    endtask

    task automatic test_stick();
        logic [7:0]  jx  [5] = '{8'h80, 8'h8B, 8'h8C, 8'h00, 8'hFF};
        logic [7:0]  ej  [5] = '{8'h00, 8'h00, 8'h0C, 8'h80, 8'h7F};
        logic [7:0]  tl  [5] = '{8'h0C, 8'h0B, 8'h00, 8'h00, 8'h00};
        logic [7:0]  tr  [5] = '{8'h0B, 8'hFF, 8'h00, 8'h00, 8'h00};
        logic [15:0] et  [5] = '{16'h000C, 16'hFF00, 16'h0000, 16'h0000, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            poll(0, 12'h000, {tr[k], tl[k], 8'h80, 8'h80, 8'h80, jx[k]});
            frame();
            n_vec++;
            if (stick_out[31:0] !== {24'h0, ej[k]}) begin
                n_err++;
                $display("FAIL stick_joy_x raw=%h: got %h want %h", jx[k], stick_out[31:0], {24'h0, ej[k]});
            end
            n_vec++;
            if (trigger_out[15:0] !== et[k]) begin
                n_err++;
                $display("FAIL trigger step %0d: got %h want %h", k, trigger_out[15:0], et[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        vsync = 1'b0;
        btn[0] = 12'h001;
        ax[0] = NEUT;
        pad_valid[0] = 1'b1;
        @(posedge clk); #1;
        pad_valid[0] = 1'b0;
        n_vec++;
        if (frame_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL sim_strobe: got %b want 1", frame_strobe);
        end
        n_vec++;
        if ({btn_held[11:0], btn_pressed[11:0]} !== 24'h000_000) begin
            n_err++;
            $display("FAIL sim_old_stage: got held=%h pressed=%h want 000/000", btn_held[11:0], btn_pressed[11:0]);
        end
        repeat (2) @(posedge clk);
        #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame();
        n_vec++;
        if ({btn_held[11:0], btn_pressed[11:0], pad_connected[0]} !== {12'h001, 12'h001, 1'b1}) begin
            n_err++;
            $display("FAIL sim_next_commit: got held=%h pressed=%h conn=%b want 001/001/1",
                     btn_held[11:0], btn_pressed[11:0], pad_connected[0]);
        end
    endtask

    task automatic test_timeout();
        logic [1:0]  ec;
        logic [11:0] eh1, er1;
        logic [31:0] es1;
        poll(1, 12'h080, {8'h00, 8'h00, 8'h80, 8'h80, 8'hC0, 8'h80});
        poll(0, 12'h002, NEUT);
        frame();
        n_vec++;
        if ({pad_connected, btn_held, stick_out[63:32]} !== {2'b11, 12'h080, 12'h002, 32'h0000_4000}) begin
            n_err++;
            $display("FAIL timeout_start: got conn=%b held=%h stick1=%h want 11/080002/00004000",
                     pad_connected, btn_held, stick_out[63:32]);
        end
        for (int k = 1; k <= 10; k++) begin
            poll(0, 12'h002, NEUT);
            frame();
            ec  = {k < 8, 1'b1};
            eh1 = (k <= 8) ? 12'h080 : 12'h000;
            er1 = (k == 9) ? 12'h080 : 12'h000;
            es1 = (k <= 8) ? 32'h0000_4000 : 32'h0;
            n_vec++;
            if (pad_connected !== ec) begin
                n_err++;
                $display("FAIL timeout_conn frame %0d: got %b want %b", k, pad_connected, ec);
            end
            n_vec++;
            if ({btn_held[23:12], btn_released[23:12], stick_out[63:32]} !== {eh1, er1, es1}) begin
                n_err++;
                $display("FAIL timeout_pad1 frame %0d: got held=%h rel=%h stick=%h want %h/%h/%h",
                         k, btn_held[23:12], btn_released[23:12], stick_out[63:32], eh1, er1, es1);
            end
            n_vec++;
            if (btn_held[11:0] !== 12'h002) begin
                n_err++;
                $display("FAIL timeout_pad0 frame %0d: got held=%h want 002", k, btn_held[11:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({frame_strobe, btn_held, btn_pressed, btn_released, stick_out, trigger_out, pad_connected} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async: got held=%h conn=%b strobe=%b want 0", btn_held, pad_connected, frame_strobe);
        end
        s0 = n_strobe;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (n_strobe !== s0) begin
            n_err++;
            $display("FAIL reset_mid_nostrobe: got %0d strobes want 0", n_strobe - s0);
        end
        frame();
        n_vec++;
        if (n_strobe - s0 !== 1) begin
            n_err++;
            $display("FAIL reset_mid_strobe: got %0d strobes want 1", n_strobe - s0);
        end
        n_vec++;
        if ({btn_held, btn_pressed, pad_connected} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_commit: got held=%h pressed=%h conn=%b want 0", btn_held, btn_pressed, pad_connected);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        pad_valid = 2'b00;
        btn[0] = '0;
        btn[1] = '0;
        ax[0] = NEUT;
        ax[1] = NEUT;
        #23 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_press_release();
        test_stick();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
